ufi_psram_wr_burst: RTL and testbench
=====================================

Name: ufi_psram_wr_burst

Overview:
- Consumes the Ufi Bus Master Write stream produced by the SPI block during PSRAM write commands (Cmd 3).
- Buffers the word stream in a FIFO of {first, adrs, data} entries.
- Repacks it into address-contiguous write bursts of up to pBurstLen words for the downstream PSRAM controller, using a request/ack command phase followed by a ready/valid data phase.
- Sits between the SPI block's Ufi write port and the PSRAM controller write port.

Parameters:
- pFifoDepth, 16, FIFO entries; power of two, at least 2*pBurstLen.
- pBurstLen, 8, maximum beats per PSRAM burst; power of two, at most pFifoDepth/2.
- pAdrsWidth, 32, Ufi / PSRAM byte address width.
- pDataWidth, 32, data word width; the address step per word is pDataWidth/8.

Ports:
- iSysClk  in  1  system clock; all logic on rising edge.
- iSysRst  in  1  asynchronous, active-low reset.
- iSUfiWd  in  pDataWidth  write data.
- iSUfiAdrs  in  pAdrsWidth  write byte address.
- iSUfiWEd  in  1  data enable, one word per cycle when high.
- iSUfiWVd  in  1  high for the whole transfer window.
- oPsrReq  out  1  burst command request.
- oPsrAdrs  out  pAdrsWidth  burst start address, stable while oPsrReq is high.
- iPsrAck  in  1  command accepted.
- oPsrWd  out  pDataWidth  beat data.
- oPsrWEd  out  1  beat valid.
- oPsrLast  out  1  final beat of the burst, qualified by oPsrWEd.
- iPsrWRdy  in  1  beat accepted when high together with oPsrWEd.
- oFifoEmpty  out  1  FIFO empty.
- oFifoFull  out  1  FIFO full.
- oOvfErr  out  1  sticky overflow flag.
- iOvfClr  in  1  clears oOvfErr.
- oBusy  out  1  state is not IDLE, or the FIFO is not empty.

Behaviour:
- Reset values:
  - oPsrReq, oPsrWEd, oPsrLast, oFifoFull, oOvfErr, oBusy = 0.
  - oPsrAdrs, oPsrWd = 0.
  - oFifoEmpty = 1.
  - FIFO pointers, closed-window counter and state are cleared.
- Reset asserted mid-operation aborts the burst immediately and drops all buffered data; no partial resumption.
- Write side:
  - Each cycle with iSUfiWEd=1 and the FIFO not full pushes {first, iSUfiAdrs, iSUfiWd}.
  - first=1 for the first push after iSUfiWVd rises.
  - A push while full is dropped and sets oOvfErr; oOvfErr holds until iOvfClr.
  - iOvfClr together with a new overflow keeps oOvfErr=1 (set wins).
  - Push and pop in the same cycle keep the count unchanged; this is legal when full, because the pop frees the slot.
- Window tracking:
  - On the iSUfiWVd falling edge, if the window pushed at least one word, rClosedCnt increments.
  - rClosedCnt decrements when the final entry of a closed window is popped. The final entry is detected as the next head having first=1, or the FIFO becoming empty while rClosedCnt>0.
  - If increment and decrement occur in the same cycle, rClosedCnt is unchanged.
- Burst trigger, evaluated in IDLE only: (count >= pBurstLen) or (count>0 and rClosedCnt>0).
- FSM states and transitions:
  - IDLE: on trigger, latch the head address into oPsrAdrs, assert oPsrReq, go to REQ.
  - REQ: hold oPsrReq and oPsrAdrs until iPsrAck=1. On the ack cycle drop oPsrReq and go to DATA. Ack on the same cycle as the request is legal; minimum REQ time is 1 cycle.
  - DATA: present the head word on oPsrWd with oPsrWEd=1. Pop on iPsrWRdy=1. oPsrLast=1 when any of the following holds for the current word:
    - it is beat pBurstLen-1;
    - the next entry has first=1;
    - the next entry's address is not the current address plus pDataWidth/8;
    - the FIFO would become empty.
  - DATA exit: on the accepted last beat go to IDLE; the next trigger is evaluated the following cycle.
- iPsrWRdy low holds oPsrWd, oPsrWEd and oPsrLast stable. No beat may be lost or duplicated.
- The FIFO never empties mid-burst. A count trigger guarantees pBurstLen entries, and a closed-window trigger guarantees the whole window is present.
- Latency: the first word is pushed in cycle N. For a closed window, oPsrReq rises no later than N+2 after the falling edge of iSUfiWVd.
- oFifoEmpty and oFifoFull are registered and exact in the cycle after the push or pop.
- Address arithmetic wraps modulo 2^pAdrsWidth; wrapping is not an error. A non-contiguous address within one window splits the burst.

Decomposition:
- Package ufi_wr_pkg:
  - typedef enum for the states IDLE/REQ/DATA;
  - struct typedef for the FIFO entry {first, adrs, data};
  - constant lpAdrsStep = pDataWidth/8.
- Sub-module ufi_sync_fifo: single-clock FIFO with first-word-fall-through head, a peek of the next entry, count, empty and full. Parameters are depth and width, with the same asynchronous active-low reset.
- The FSM, window counter and overflow logic live in the top module.

Test Plan:
- Reset: hold iSysRst=0 -> every output at its reset value, oFifoEmpty=1; release -> oBusy stays 0.
- Burst of 8: 8 words at addresses 0x1000..0x101C, data 0..7, iSUfiWVd high throughout -> one request with oPsrAdrs=0x1000, 8 beats with data 0..7, oPsrLast on data 7.
- Flush: 11 words from 0x2000, then iSUfiWVd falls -> bursts at 0x2000 (8 beats) and 0x2020 (3 beats), oPsrLast on the 3rd beat, rClosedCnt back to 0.
- Backpressure: toggle iPsrWRdy 1-0-0-1 and ack after 5 cycles -> output data sequence identical to the input, no duplicated beats.
- Overflow: hold iPsrAck=0 and push 17 words -> 16 stored, oFifoFull=1, oOvfErr=1, the 17th word is absent from the PSRAM output; iOvfClr -> oOvfErr=0.
- Non-contiguous address and reset mid-burst: address jump 0x3008 -> 0x4000 ends the burst at 0x3008 and starts a new one at 0x4000; iSysRst=0 during DATA -> outputs return to reset values next edge, FIFO empty.

Source files
------------

// File: rtl/ufi_wr_pkg.sv
// ---------------------------------------------------------------------------
// ufi_wr_pkg
// Shared types and constants for the Ufi-to-PSRAM write burst packer.
//   wr_state_e  : burst FSM states (IDLE / REQ / DATA)
//   wr_entry_t  : FIFO entry {first, adrs, data} at the default bus widths
//   lpAdrsStep  : byte address increment between consecutive data words
// ---------------------------------------------------------------------------
package ufi_wr_pkg;

  localparam int lpAdrsWidth = 32;
  localparam int lpDataWidth = 32;
  localparam int lpAdrsStep  = lpDataWidth / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic                   first;
    logic [lpAdrsWidth-1:0] adrs;
    logic [lpDataWidth-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/ufi_sync_fifo.sv
// ---------------------------------------------------------------------------
// ufi_sync_fifo
// Single-clock FIFO with a first-word-fall-through head and a peek at the
// entry behind the head.
//   clk, rst_n    : clock, asynchronous active-low reset
//   push, wr_data : write request and word (ignored when full with no pop)
//   pop           : remove the head (ignored when empty)
//   head, nxt     : current head entry and the entry after it
//   count         : number of stored entries
//   empty, full   : registered status, exact the cycle after a push/pop
// ---------------------------------------------------------------------------
module ufi_sync_fifo #(
  parameter int pDepth = 16,
  parameter int pWidth = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [pWidth-1:0]       wr_data,
  input  logic                    pop,
  output logic [pWidth-1:0]       head,
  output logic [pWidth-1:0]       nxt,
  output logic [$clog2(pDepth):0] count,
  output logic                    empty,
  output logic                    full
);

  localparam int lpPtrW = $clog2(pDepth);

  logic [pWidth-1:0] mem [pDepth];
  logic [lpPtrW-1:0] wr_ptr;
  logic [lpPtrW-1:0] rd_ptr;
  logic [lpPtrW:0]   count_nxt;
  logic              do_push;
  logic              do_pop;

  // A write into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = mem[rd_ptr];
  assign nxt  = mem[rd_ptr + lpPtrW'(1)];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + (lpPtrW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - (lpPtrW+1)'(1);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + lpPtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + lpPtrW'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == (lpPtrW+1)'(pDepth));
    end
  end

endmodule

// File: rtl/ufi_psram_wr_burst.sv
// ---------------------------------------------------------------------------
// ufi_psram_wr_burst
// Buffers the Ufi master write stream and repacks it into address-contiguous
// PSRAM write bursts of up to pBurstLen beats.
//   iSysClk, iSysRst            : clock, asynchronous active-low reset
//   iSUfiWd/Adrs/WEd/WVd        : Ufi write word, address, enable, window
//   oPsrReq, oPsrAdrs, iPsrAck  : burst command handshake and start address
//   oPsrWd/WEd/Last, iPsrWRdy   : burst data beats (ready/valid)
//   oFifoEmpty, oFifoFull       : buffer status
//   oOvfErr, iOvfClr            : sticky dropped-word flag and its clear
//   oBusy                       : burst in progress or data still buffered
// ---------------------------------------------------------------------------
module ufi_psram_wr_burst
  import ufi_wr_pkg::*;
#(
  parameter int pFifoDepth = 16,
  parameter int pBurstLen  = 8,
  parameter int pAdrsWidth = lpAdrsWidth,
  parameter int pDataWidth = lpDataWidth
) (
  input  logic                  iSysClk,
  input  logic                  iSysRst,
  input  logic [pDataWidth-1:0] iSUfiWd,
  input  logic [pAdrsWidth-1:0] iSUfiAdrs,
  input  logic                  iSUfiWEd,
  input  logic                  iSUfiWVd,
  output logic                  oPsrReq,
  output logic [pAdrsWidth-1:0] oPsrAdrs,
  input  logic                  iPsrAck,
  output logic [pDataWidth-1:0] oPsrWd,
  output logic                  oPsrWEd,
  output logic                  oPsrLast,
  input  logic                  iPsrWRdy,
  output logic                  oFifoEmpty,
  output logic                  oFifoFull,
  output logic                  oOvfErr,
  input  logic                  iOvfClr,
  output logic                  oBusy
);

  localparam int lpCntW  = $clog2(pFifoDepth) + 1;
  localparam int lpBeatW = (pBurstLen > 1) ? $clog2(pBurstLen) : 1;
  localparam logic [pAdrsWidth-1:0] lpStep = pAdrsWidth'(pDataWidth / 8);

  typedef struct packed {
    logic                  first;
    logic [pAdrsWidth-1:0] adrs;
    logic [pDataWidth-1:0] data;
  } entry_t;

  entry_t             wr_ent;
  entry_t             head_ent;
  entry_t             nxt_ent;
  logic [lpCntW-1:0]  count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               ovf_set;
  wr_state_e          state;
  logic [lpBeatW-1:0] beat;
  logic [lpBeatW-1:0] load_idx;
  logic               load_last;
  logic [lpCntW-1:0]  closed_cnt;
  logic               wvd_d;
  logic               first_pend;
  logic               win_pushed;
  logic               win_open;
  logic               closed_inc;
  logic               closed_dec;
  logic               trigger;

  // A word is popped exactly when it is loaded into the output beat register:
  // on the command ack, and on each accepted non-final beat.
  assign pop = ((state == REQ) && iPsrAck) ||
               ((state == DATA) && iPsrWRdy && !oPsrLast);

  assign push    = iSUfiWEd && (!fifo_full || pop);
  assign ovf_set = iSUfiWEd && fifo_full && !pop;

  assign win_open      = iSUfiWVd && !wvd_d;
  assign wr_ent.first  = first_pend || win_open;
  assign wr_ent.adrs   = iSUfiAdrs;
  assign wr_ent.data   = iSUfiWd;

  // A window whose last word is popped in the very cycle it closes must still
  // cancel its own increment, hence closed_inc in the decrement qualifier.
  assign closed_inc = wvd_d && !iSUfiWVd && (win_pushed || push);
  assign closed_dec = pop && ((closed_cnt != '0) || closed_inc) &&
                      ((count == lpCntW'(1)) || nxt_ent.first);

  assign trigger = (count >= lpCntW'(pBurstLen)) ||
                   ((count != '0) && (closed_cnt != '0));

  // The word being loaded closes the burst on the beat limit, a window
  // boundary, an address discontinuity, or when it is the last one buffered.
  assign load_idx  = (state == REQ) ? '0 : beat + lpBeatW'(1);
  assign load_last = (load_idx == lpBeatW'(pBurstLen - 1)) ||
                     (count == lpCntW'(1)) ||
                     nxt_ent.first ||
                     (nxt_ent.adrs != head_ent.adrs + lpStep);

  assign oFifoEmpty = fifo_empty;
  assign oFifoFull  = fifo_full;
  assign oBusy      = (state != IDLE) || !fifo_empty;

  ufi_sync_fifo #(
    .pDepth (pFifoDepth),
    .pWidth ($bits(entry_t))
  ) u_fifo (
    .clk     (iSysClk),
    .rst_n   (iSysRst),
    .push    (push),
    .wr_data (wr_ent),
    .pop     (pop),
    .head    (head_ent),
    .nxt     (nxt_ent),
    .count   (count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Window edge tracking, count of fully written windows still buffered, and
  // the sticky overflow flag (a new overflow beats a simultaneous clear).
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      wvd_d      <= 1'b0;
      first_pend <= 1'b0;
      win_pushed <= 1'b0;
      closed_cnt <= '0;
      oOvfErr    <= 1'b0;
    end else begin
      wvd_d <= iSUfiWVd;
      if (win_open) begin
        first_pend <= !push;
        win_pushed <= push;
      end else if (push) begin
        first_pend <= 1'b0;
        win_pushed <= 1'b1;
      end
      if (closed_inc && !closed_dec) begin
        closed_cnt <= closed_cnt + lpCntW'(1);
      end else if (closed_dec && !closed_inc) begin
        closed_cnt <= closed_cnt - lpCntW'(1);
      end
      if (ovf_set) begin
        oOvfErr <= 1'b1;
      end else if (iOvfClr) begin
        oOvfErr <= 1'b0;
      end
    end
  end

  // Burst FSM with registered command and beat outputs.
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      state    <= IDLE;
      oPsrReq  <= 1'b0;
      oPsrAdrs <= '0;
      oPsrWd   <= '0;
      oPsrWEd  <= 1'b0;
      oPsrLast <= 1'b0;
      beat     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            oPsrAdrs <= head_ent.adrs;
            oPsrReq  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (iPsrAck) begin
            oPsrReq  <= 1'b0;
            oPsrWd   <= head_ent.data;
            oPsrWEd  <= 1'b1;
            oPsrLast <= load_last;
            beat     <= load_idx;
            state    <= DATA;
          end
        end
        DATA: begin
          if (iPsrWRdy) begin
            if (oPsrLast) begin
              oPsrWEd  <= 1'b0;
              oPsrLast <= 1'b0;
              state    <= IDLE;
            end else begin
              oPsrWd   <= head_ent.data;
              oPsrLast <= load_last;
              beat     <= load_idx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ufi_psram_wr_burst.sv
// ---------------------------------------------------------------------------
// tb_ufi_psram_wr_burst
// Scoreboard bench: every accepted Ufi word is queued as an expected PSRAM
// beat; a monitor checks command addresses, beat data, beat addresses and
// burst termination against the queued stream.
// ---------------------------------------------------------------------------
module tb_ufi_psram_wr_burst;

  localparam int BL = 8;

  typedef struct packed {
    logic        first;
    logic [31:0] adrs;
    logic [31:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] wadrs = '0;
  logic        wed = 1'b0;
  logic        wvd = 1'b0;
  logic        psr_req;
  logic [31:0] psr_adrs;
  logic        psr_ack = 1'b0;
  logic [31:0] psr_wd;
  logic        psr_wed;
  logic        psr_last;
  logic        psr_wrdy = 1'b0;
  logic        fifo_empty;
  logic        fifo_full;
  logic        ovf_err;
  logic        ovf_clr = 1'b0;
  logic        busy;

  word_t       exp_q[$];
  logic [31:0] win_adrs[$];
  logic [31:0] win_data[$];
  int          checks = 0;
  int          failures = 0;
  int          req_seen = 0;
  int          beat_idx = 0;
  bit          mon_en = 1'b0;
  int          rdy_mode = 2;
  bit          ack_en = 1'b1;
  bit          ack_rand = 1'b0;
  int          ack_fixed = 0;

  always #5 clk = ~clk;

  ufi_psram_wr_burst dut (
    .iSysClk    (clk),
    .iSysRst    (rst_n),
    .iSUfiWd    (wd),
    .iSUfiAdrs  (wadrs),
    .iSUfiWEd   (wed),
    .iSUfiWVd   (wvd),
    .oPsrReq    (psr_req),
    .oPsrAdrs   (psr_adrs),
    .iPsrAck    (psr_ack),
    .oPsrWd     (psr_wd),
    .oPsrWEd    (psr_wed),
    .oPsrLast   (psr_last),
    .iPsrWRdy   (psr_wrdy),
    .oFifoEmpty (fifo_empty),
    .oFifoFull  (fifo_full),
    .oOvfErr    (ovf_err),
    .iOvfClr    (ovf_clr),
    .oBusy      (busy)
  );

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Downstream PSRAM model: ack after a delay, ready random/patterned/fixed.
  initial begin
    int age;
    int dly;
    int pat_idx;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    age = 0;
    dly = 0;
    pat_idx = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       psr_wrdy = ($urandom_range(0, 3) != 0);
        1: begin psr_wrdy = pat[pat_idx % 4]; pat_idx++; end
        2:       psr_wrdy = 1'b1;
        default: psr_wrdy = 1'b0;
      endcase
      if (!psr_req) begin
        age = 0;
        psr_ack = 1'b0;
        dly = ack_rand ? int'($urandom_range(0, 4)) : ack_fixed;
      end else begin
        psr_ack = ack_en && (age >= dly);
        age++;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted beat.
  initial begin
    word_t       w;
    logic [31:0] beat_adrs;
    bit          exp_last;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (psr_req && psr_ack) begin
          req_seen++;
          beat_idx = 0;
          if (exp_q.size() == 0) check_value("req_unexpected", psr_adrs, 32'hxxxxxxxx);
          else check_value("req_adrs", psr_adrs, exp_q[0].adrs);
        end
        if (psr_wed && psr_wrdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL extra_beat actual data=%h required no beat", psr_wd);
          end else begin
            w = exp_q.pop_front();
            beat_adrs = psr_adrs + 32'(beat_idx * 4);
            exp_last = (beat_idx == BL - 1) || (exp_q.size() == 0) ||
                       exp_q[0].first || (exp_q[0].adrs != w.adrs + 32'd4);
            check_value("beat_data", psr_wd, w.data);
            check_value("beat_adrs", beat_adrs, w.adrs);
            check_value("beat_last", 32'(psr_last), 32'(exp_last));
            beat_idx++;
          end
        end
      end
    end
  end

  // Pushes win_adrs/win_data as one Ufi window; the first n_record words are
  // expected downstream. With limit set, words outstanding stay below 12.
  task automatic send_window(input int n_record, input bit close, input bit limit, input int gap_max);
    word_t w;
    int    guard;
    for (int i = 0; i < win_adrs.size(); i++) begin
      guard = 0;
      wed = 1'b0;
      while (limit && exp_q.size() >= 12 && guard < 2000) begin
        step(1);
        guard++;
      end
      if (guard >= 2000) check_value("flow_timeout", 32'(exp_q.size()), 32'd11);
      if (gap_max > 0) step($urandom_range(0, gap_max));
      wvd = 1'b1;
      wed = 1'b1;
      wadrs = win_adrs[i];
      wd = win_data[i];
      if (i < n_record) begin
        w.first = (i == 0);
        w.adrs = win_adrs[i];
        w.data = win_data[i];
        exp_q.push_back(w);
      end
      step(1);
    end
    wed = 1'b0;
    if (close) begin
      wvd = 1'b0;
      step(2);
    end
  endtask

  task automatic set_window(input logic [31:0] base, input int n, input bit seq_data);
    win_adrs.delete();
    win_data.delete();
    for (int i = 0; i < n; i++) begin
      win_adrs.push_back(base + 32'(i * 4));
      win_data.push_back(seq_data ? 32'(i) : $urandom);
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 3000) begin
      step(1);
      guard++;
    end
    checks++;
    if (guard >= 3000) begin
      failures++;
      $display("[TB] FAIL %s_drain actual pending=%0d busy=%0d required pending=0 busy=0",
               name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  initial begin
    int req_base;
    int guard;
    bit req_any;

    // Reset values.
    step(3);
    check_value("rst_req", 32'(psr_req), 0);
    check_value("rst_adrs", psr_adrs, 0);
    check_value("rst_wd", psr_wd, 0);
    check_value("rst_wed", 32'(psr_wed), 0);
    check_value("rst_last", 32'(psr_last), 0);
    check_value("rst_empty", 32'(fifo_empty), 1);
    check_value("rst_full", 32'(fifo_full), 0);
    check_value("rst_ovf", 32'(ovf_err), 0);
    check_value("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step(3);
    check_value("post_rst_busy", 32'(busy), 0);
    mon_en = 1'b1;

    // Single full burst of 8.
    req_base = req_seen;
    set_window(32'h1000, 8, 1'b1);
    send_window(8, 1'b1, 1'b0, 0);
    drain("burst8");
    check_value("burst8_reqs", 32'(req_seen - req_base), 1);

    // Closing a window flushes the 3-word remainder.
    req_base = req_seen;
    set_window(32'h2000, 11, 1'b0);
    send_window(11, 1'b1, 1'b0, 0);
    drain("flush");
    check_value("flush_reqs", 32'(req_seen - req_base), 2);

    // With no closed window left, a short open window must not start a burst.
    req_base = req_seen;
    set_window(32'h2800, 3, 1'b0);
    send_window(3, 1'b0, 1'b0, 0);
    req_any = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (psr_req) req_any = 1'b1;
      step(1);
    end
    check_value("open_window_idle", 32'(req_any), 0);
    wvd = 1'b0;
    drain("open_window");
    check_value("open_window_reqs", 32'(req_seen - req_base), 1);

    // Backpressure: ready 1-0-0-1, ack after 5 cycles.
    rdy_mode = 1;
    ack_fixed = 5;
    set_window(32'h7000, 10, 1'b0);
    send_window(10, 1'b1, 1'b0, 0);
    set_window(32'h7100, 5, 1'b0);
    send_window(5, 1'b1, 1'b0, 1);
    drain("backpressure");
    rdy_mode = 2;
    ack_fixed = 0;

    // Overflow: 17 words with no ack; only 16 are kept.
    req_base = req_seen;
    ack_en = 1'b0;
    set_window(32'h5000, 17, 1'b0);
    send_window(16, 1'b1, 1'b0, 0);
    check_value("ovf_full", 32'(fifo_full), 1);
    check_value("ovf_flag", 32'(ovf_err), 1);
    check_value("ovf_req_waiting", 32'(psr_req), 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check_value("ovf_cleared", 32'(ovf_err), 0);
    ack_en = 1'b1;
    drain("overflow");
    check_value("ovf_reqs", 32'(req_seen - req_base), 2);
    check_value("ovf_empty_after", 32'(fifo_empty), 1);

    // Address discontinuity inside one window splits the burst.
    req_base = req_seen;
    win_adrs = '{32'h3000, 32'h3004, 32'h3008, 32'h4000, 32'h4004};
    win_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
    send_window(5, 1'b1, 1'b0, 0);
    drain("jump");
    check_value("jump_reqs", 32'(req_seen - req_base), 2);

    // Randomized traffic: random lengths, jumps, wrap-around, ready and ack.
    rdy_mode = 0;
    ack_rand = 1'b1;
    for (int n = 0; n < 30; n++) begin
      logic [31:0] base;
      int len;
      len = $urandom_range(1, 12);
      base = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 : ($urandom & 32'hFFFFFFFC);
      set_window(base, len, 1'b0);
      for (int i = 1; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) win_adrs[i] = $urandom & 32'hFFFFFFFC;
        else win_adrs[i] = win_adrs[i-1] + 32'd4;
      end
      send_window(len, 1'b1, 1'b1, 2);
    end
    drain("random");
    check_value("random_empty", 32'(fifo_empty), 1);
    rdy_mode = 2;
    ack_rand = 1'b0;

    // Reset in the middle of a data phase drops everything.
    rdy_mode = 3;
    set_window(32'h6000, 8, 1'b0);
    send_window(8, 1'b1, 1'b0, 0);
    guard = 0;
    while (!psr_wed && guard < 100) begin
      step(1);
      guard++;
    end
    check_value("midrst_reached_data", 32'(psr_wed), 1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_value("midrst_wed", 32'(psr_wed), 0);
    check_value("midrst_wd", psr_wd, 0);
    check_value("midrst_req", 32'(psr_req), 0);
    check_value("midrst_empty", 32'(fifo_empty), 1);
    check_value("midrst_busy", 32'(busy), 0);
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    rdy_mode = 2;
    step(2);
    mon_en = 1'b1;
    req_base = req_seen;
    set_window(32'h6100, 3, 1'b0);
    send_window(3, 1'b1, 1'b0, 0);
    drain("after_rst");
    check_value("after_rst_reqs", 32'(req_seen - req_base), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
